tdp_ram_be: RTL and testbench

Parametrised true dual-port RAM, single clock, for the transaction-layer buffers (posted/non-posted/completion storage and FIFO backing). It extends the plain two-port RAM with:
- byte-lane write enables
- a selectable same-port read-during-write mode
- an optional output pipeline register with read-valid flags
- a post-reset memory clear sequence
- same-address write-collision detection

---
 rtl/tdp_ram_pkg.sv | 11 +
 rtl/tdp_ram_be_if.sv | 12 +
 rtl/tdp_ram_port.sv | 52 +++++
 rtl/tdp_ram_be.sv | 64 ++++++
 tb/tb_tdp_ram_be.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/tdp_ram_pkg.sv
// tdp_ram_pkg: shared FSM states, read-mode encodings and byte-mask helper
package tdp_ram_pkg;
  typedef enum logic {INIT, READY} state_e;
  localparam int WRITE_FIRST = 0;
  localparam int READ_FIRST = 1;
  localparam int MAX_W = 1024;
  localparam int MAX_B = MAX_W / 8;
  function automatic logic [MAX_W-1:0] be_mask(input logic [MAX_B-1:0] be);
    for (int i = 0; i < MAX_B; i++) be_mask[8*i +: 8] = {8{be[i]}};
  endfunction
endpackage

// File: rtl/tdp_ram_be_if.sv
// tdp_ram_be_if: one RAM port (request, write data, read response)
interface tdp_ram_be_if #(parameter int DATA_WIDTH = 32, parameter int ADDR_WIDTH = 4);
  logic en;
  logic we;
  logic [DATA_WIDTH/8-1:0] be;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic rvalid;
  modport master (output en, we, be, addr, wdata, input rdata, rvalid);
  modport slave (input en, we, be, addr, wdata, output rdata, rvalid);
endinterface

// File: rtl/tdp_ram_port.sv
// tdp_ram_port: byte-lane merge, read-mode select and read pipeline for one port
module tdp_ram_port import tdp_ram_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int RD_MODE = WRITE_FIRST,
  parameter int OUT_REG = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic acc_i,
  input  logic wr_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [DATA_WIDTH-1:0] old_i,
  output logic [DATA_WIDTH-1:0] merged_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic rvalid_o
);
  logic [DATA_WIDTH-1:0] mask;
  logic [DATA_WIDTH-1:0] d1_q, d1_d;
  logic v1_q;
  assign mask = DATA_WIDTH'(be_mask(MAX_B'(be_i)));
  assign merged_o = (old_i & ~mask) | (wdata_i & mask);
  // wr_i is low for a discarded write, so such a port returns the pre-write word
  always_comb d1_d = acc_i ? ((wr_i && RD_MODE == WRITE_FIRST) ? merged_o : old_i) : d1_q;
  // first read stage: capture the word on every accepted access, hold otherwise
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      d1_q <= '0;
      v1_q <= 1'b0;
    end else begin
      d1_q <= d1_d;
      v1_q <= acc_i;
    end
  if (OUT_REG != 0) begin : g_oreg
    logic [DATA_WIDTH-1:0] d2_q;
    logic v2_q;
    // optional output stage: advances only when stage one holds a valid word
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        d2_q <= '0;
        v2_q <= 1'b0;
      end else begin
        d2_q <= v1_q ? d1_q : d2_q;
        v2_q <= v1_q;
      end
    assign rdata_o = d2_q;
    assign rvalid_o = v2_q;
  end else begin : g_noreg
    assign rdata_o = d1_q;
    assign rvalid_o = v1_q;
  end
endmodule

// File: rtl/tdp_ram_be.sv
// tdp_ram_be: true dual-port byte-enable RAM with post-reset clear and collision flag
module tdp_ram_be import tdp_ram_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int RD_MODE = WRITE_FIRST,
  parameter int OUT_REG = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic clk,
  input  logic reset,
  tdp_ram_be_if.slave a,
  tdp_ram_be_if.slave b,
  output logic init_busy,
  output logic collision
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic coll_q, coll_d;
  logic ready, a_acc, b_acc, a_wr, b_wr;
  logic [DATA_WIDTH-1:0] a_old, b_old, a_merged, b_merged;
  assign ready = state_q == READY;
  assign a_acc = ready & a.en;
  assign b_acc = ready & b.en;
  assign a_wr = a_acc & a.we;
  assign coll_d = a_wr & b_acc & b.we & (a.addr == b.addr);
  assign b_wr = b_acc & b.we & ~coll_d;
  assign a_old = mem[a.addr];
  assign b_old = mem[b.addr];
  assign init_busy = ~ready;
  assign collision = coll_q;
  // clear walk: one address per cycle, leave INIT after the last address
  always_comb begin
    cnt_d = ready ? cnt_q : cnt_q + 1'b1;
    state_d = (!ready && cnt_q == '1) ? READY : state_q;
  end
  // FSM, clear counter and collision pulse registers
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= (CLEAR_ON_RESET != 0) ? INIT : READY;
      cnt_q <= '0;
      coll_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      coll_q <= coll_d;
    end
  // storage: untouched by reset, zeroed by the clear walk, port A wins collisions
  always_ff @(posedge clk)
    if (!ready) mem[cnt_q] <= '0;
    else begin
      if (a_wr) mem[a.addr] <= a_merged;
      if (b_wr) mem[b.addr] <= b_merged;
    end
  tdp_ram_port #(.DATA_WIDTH(DATA_WIDTH), .RD_MODE(RD_MODE), .OUT_REG(OUT_REG)) u_a (
    .clk(clk), .reset(reset), .acc_i(a_acc), .wr_i(a_wr), .be_i(a.be), .wdata_i(a.wdata),
    .old_i(a_old), .merged_o(a_merged), .rdata_o(a.rdata), .rvalid_o(a.rvalid)
  );
  tdp_ram_port #(.DATA_WIDTH(DATA_WIDTH), .RD_MODE(RD_MODE), .OUT_REG(OUT_REG)) u_b (
    .clk(clk), .reset(reset), .acc_i(b_acc), .wr_i(b_wr), .be_i(b.be), .wdata_i(b.wdata),
    .old_i(b_old), .merged_o(b_merged), .rdata_o(b.rdata), .rvalid_o(b.rvalid)
  );
endmodule

// File: tb/tb_tdp_ram_be.sv
// tb_tdp_ram_be: write-first/no-register and read-first/registered instances against a reference model
module tb_tdp_ram_be;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  logic a_en = 0, a_we = 0, b_en = 0, b_we = 0;
  logic [3:0] a_be = 0, b_be = 0, a_addr = 0, b_addr = 0;
  logic [31:0] a_wd = 0, b_wd = 0;
  logic busy0, busy1, coll0, coll1;
  tdp_ram_be_if a0(), b0(), a1(), b1();
  assign a0.en = a_en; assign a0.we = a_we; assign a0.be = a_be; assign a0.addr = a_addr; assign a0.wdata = a_wd;
  assign a1.en = a_en; assign a1.we = a_we; assign a1.be = a_be; assign a1.addr = a_addr; assign a1.wdata = a_wd;
  assign b0.en = b_en; assign b0.we = b_we; assign b0.be = b_be; assign b0.addr = b_addr; assign b0.wdata = b_wd;
  assign b1.en = b_en; assign b1.we = b_we; assign b1.be = b_be; assign b1.addr = b_addr; assign b1.wdata = b_wd;
  tdp_ram_be #(.RD_MODE(0), .OUT_REG(0), .CLEAR_ON_RESET(1)) u0 (
    .clk(clk), .reset(reset), .a(a0), .b(b0), .init_busy(busy0), .collision(coll0));
  tdp_ram_be #(.RD_MODE(1), .OUT_REG(1), .CLEAR_ON_RESET(1)) u1 (
    .clk(clk), .reset(reset), .a(a1), .b(b1), .init_busy(busy1), .collision(coll1));

  typedef logic [31:0] wq_t[$];
  typedef struct {
    bit ae, awe; logic [3:0] abe, aad; logic [31:0] awd;
    bit ben, bwe; logic [3:0] bbe, bad; logic [31:0] bwd;
    logic [31:0] xa0, xa1, xb0, xb1;
  } vec_t;
  wq_t q[4];
  bit ev[4];
  bit pa, pb, ec, m_busy;
  int m_cnt;
  logic [31:0] mem_m [16];
  int errors = 0, checks = 0;
  vec_t tv[10];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic sb(input int i, input string n, input logic v, input logic [31:0] d);
    chk({n, "_rvalid"}, {31'b0, v}, {31'b0, ev[i]});
    if (v) begin
      if (q[i].size() == 0) begin
        checks++; errors++;
        $display("FAIL %s_data: got %h expected no response", n, d);
      end else chk({n, "_data"}, d, q[i].pop_front());
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w, input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
    return (o & ~m) | (w & m);
  endfunction

  task automatic check_out();
    chk("init_busy0", {31'b0, busy0}, {31'b0, m_busy});
    chk("init_busy1", {31'b0, busy1}, {31'b0, m_busy});
    chk("collision0", {31'b0, coll0}, {31'b0, ec});
    chk("collision1", {31'b0, coll1}, {31'b0, ec});
    sb(0, "a0", a0.rvalid, a0.rdata);
    sb(1, "b0", b0.rvalid, b0.rdata);
    sb(2, "a1", a1.rvalid, a1.rdata);
    sb(3, "b1", b1.rvalid, b1.rdata);
  endtask

  task automatic step(input bit ae, input bit awe, input logic [3:0] abe, input logic [3:0] aad,
                      input logic [31:0] awd, input bit ben, input bit bwe, input logic [3:0] bbe,
                      input logic [3:0] bad, input logic [31:0] bwd, input bit tab,
                      input logic [31:0] xa0, input logic [31:0] xa1, input logic [31:0] xb0,
                      input logic [31:0] xb1);
    logic [31:0] oa, ob, ma, mb;
    bit acc_a, acc_b, cl, bw;
    a_en = ae; a_we = awe; a_be = abe; a_addr = aad; a_wd = awd;
    b_en = ben; b_we = bwe; b_be = bbe; b_addr = bad; b_wd = bwd;
    oa = mem_m[aad]; ob = mem_m[bad];
    ma = merge(oa, awd, abe); mb = merge(ob, bwd, bbe);
    acc_a = ae && !m_busy; acc_b = ben && !m_busy;
    cl = acc_a && awe && acc_b && bwe && aad == bad;
    bw = acc_b && bwe && !cl;
    if (acc_a) begin
      q[0].push_back(tab ? xa0 : (awe ? ma : oa));
      q[2].push_back(tab ? xa1 : oa);
    end
    if (acc_b) begin
      q[1].push_back(tab ? xb0 : (bw ? mb : ob));
      q[3].push_back(tab ? xb1 : ob);
    end
    if (acc_a && awe) mem_m[aad] = ma;
    if (bw) mem_m[bad] = mb;
    if (m_busy) begin
      mem_m[m_cnt] = 32'h0;
      m_busy = m_cnt != 15;
      m_cnt++;
    end
    ev[0] = acc_a; ev[1] = acc_b; ev[2] = pa; ev[3] = pb;
    pa = acc_a; pb = acc_b; ec = cl;
    @(posedge clk);
    @(negedge clk);
    check_out();
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rd(input bit ae, input logic [3:0] aad, input bit ben, input logic [3:0] bad);
    step(ae, 0, 0, aad, 0, ben, 0, 0, bad, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    a_en = 0; b_en = 0; a_we = 0; b_we = 0;
    reset = 1'b1;
    #1;
    chk("rst_busy", {30'b0, busy1, busy0}, 32'h3);
    chk("rst_rvalid", {28'b0, a0.rvalid, b0.rvalid, a1.rvalid, b1.rvalid}, 32'h0);
    chk("rst_coll", {30'b0, coll1, coll0}, 32'h0);
    chk("rst_rdata_a0", a0.rdata, 32'h0);
    chk("rst_rdata_b1", b1.rdata, 32'h0);
    for (int i = 0; i < 4; i++) begin q[i].delete(); ev[i] = 0; end
    pa = 0; pb = 0; ec = 0; m_busy = 1; m_cnt = 0;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    tv[0] = '{1, 1, 4'hf, 3, 32'hAABBCCDD, 0, 0, 0, 0, 0, 32'hAABBCCDD, 32'h0, 32'h0, 32'h0};
    tv[1] = '{1, 1, 4'h5, 3, 32'h11223344, 0, 0, 0, 0, 0, 32'hAA22CC44, 32'hAABBCCDD, 32'h0, 32'h0};
    tv[2] = '{1, 0, 4'h0, 3, 32'h0, 0, 0, 0, 0, 0, 32'hAA22CC44, 32'hAA22CC44, 32'h0, 32'h0};
    tv[3] = '{1, 1, 4'hf, 5, 32'hDEADBEEF, 1, 0, 0, 5, 0, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0};
    tv[4] = '{1, 0, 4'h0, 5, 32'h0, 1, 0, 0, 5, 0, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
    tv[5] = '{1, 1, 4'hf, 7, 32'h1, 1, 1, 4'hf, 7, 32'h2, 32'h1, 32'h0, 32'h0, 32'h0};
    tv[6] = '{1, 0, 4'h0, 7, 32'h0, 1, 0, 0, 7, 0, 32'h1, 32'h1, 32'h1, 32'h1};
    tv[7] = '{1, 1, 4'h0, 3, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 32'hAA22CC44, 32'hAA22CC44, 32'h0, 32'h0};
    tv[8] = '{1, 0, 4'h0, 9, 32'h0, 1, 1, 4'h3, 9, 32'h12345678, 32'h0, 32'h0, 32'h00005678, 32'h0};
    tv[9] = '{1, 0, 4'h0, 9, 32'h0, 1, 0, 0, 3, 0, 32'h00005678, 32'h00005678, 32'hAA22CC44, 32'hAA22CC44};
    @(negedge clk);
    do_reset();
    idle(16);
    for (int i = 0; i < 16; i++) rd(1, 4'(i), 0, 0);
    idle(2);
    foreach (tv[i])
      step(tv[i].ae, tv[i].awe, tv[i].abe, tv[i].aad, tv[i].awd, tv[i].ben, tv[i].bwe, tv[i].bbe,
           tv[i].bad, tv[i].bwd, 1, tv[i].xa0, tv[i].xa1, tv[i].xb0, tv[i].xb1);
    idle(2);
    for (int i = 0; i < 8; i++) step(1, 1, 4'hf, 4'(i), 32'hC0DE0000 + 32'(i), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) rd(0, 0, 1, 4'(i));
    idle(3);
    for (int i = 0; i < 60; i++)
      step(1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom_range(0, 3)), $urandom,
           1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom_range(0, 3)), $urandom,
           0, 0, 0, 0, 0);
    idle(3);
    rd(1, 2, 1, 3);
    rd(1, 4, 1, 5);
    do_reset();
    for (int i = 0; i < 6; i++) rd(1, 4'(i), 1, 4'(i));
    do_reset();
    idle(15);
    chk("init_still_busy", {31'b0, busy0}, 32'h1);
    idle(1);
    rd(1, 7, 1, 0);
    idle(3);
    for (int i = 0; i < 4; i++) chk("queue_drained", q[i].size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
